cgra_config_responder: RTL and testbench



---
 rtl/cgra_config_pkg.sv | 19 +
 rtl/cgra_config_addr_decode.sv | 39 +++
 rtl/cgra_config_responder.sv | 133 +++++++++++++
 tb/tb_cgra_config_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_config_pkg.sv
// rtl/cgra_config_pkg.sv - shared address field layout, idle constant and FSM states
package cgra_config_pkg;

  localparam int TILE_LSB    = 0;
  localparam int TILE_W      = 16;
  localparam int FEATURE_LSB = 16;
  localparam int FEATURE_W   = 8;
  localparam int REG_LSB     = 24;
  localparam int REG_W       = 8;

  localparam logic [31:0] IDLE_ADDR = 32'h0;

  typedef enum logic [1:0] {
    CFG_WAIT,
    CFG_LOAD,
    CFG_DONE
  } cfg_state_t;

endpackage

// File: rtl/cgra_config_addr_decode.sv
// rtl/cgra_config_addr_decode.sv - combinational config address decode (CONFIG_READBACK_EN selects read support)
module cgra_config_addr_decode
  import cgra_config_pkg::*;
#(
  parameter logic [TILE_W-1:0]    TILE_ID    = 16'h0001,
  parameter logic [FEATURE_W-1:0] FEATURE_ID = 8'h00,
  parameter int                   NUM_REGS   = 8
) (
  input  logic [31:0]      addr,
  input  logic             read_req,
  output logic             hit,
  output logic             is_write,
  output logic             is_read,
  output logic [REG_W-1:0] index,
  output logic             out_of_range
);

  assign index = addr[REG_LSB +: REG_W];

  // The idle word never matches because TILE_ID is required to be nonzero.
  assign hit = (addr != IDLE_ADDR)
            && (addr[TILE_LSB +: TILE_W] == TILE_ID)
            && (addr[FEATURE_LSB +: FEATURE_W] == FEATURE_ID);

  // One extra bit so NUM_REGS = 256 compares correctly.
  assign out_of_range = ({1'b0, index} >= (REG_W + 1)'(NUM_REGS));

`ifdef CONFIG_READBACK_EN
  assign is_read  = hit & read_req;
  assign is_write = hit & ~read_req & ~out_of_range;
`else
  // Read request pin kept for netlist compatibility but has no effect.
  logic unused_read_req;
  assign unused_read_req = read_req;
  assign is_read  = 1'b0;
  assign is_write = hit & ~out_of_range;
`endif

endmodule

// File: rtl/cgra_config_responder.sv
// rtl/cgra_config_responder.sv - per-tile config stream responder; readback enabled by CONFIG_READBACK_EN
module cgra_config_responder
  import cgra_config_pkg::*;
#(
  parameter logic [TILE_W-1:0]    TILE_ID     = 16'h0001,
  parameter logic [FEATURE_W-1:0] FEATURE_ID  = 8'h00,
  parameter int                   NUM_REGS    = 8,
  parameter int                   IDLE_CYCLES = 4
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [31:0]              config_addr_in,
  input  logic [31:0]              config_data_in,
  input  logic                     config_read_in,
  output logic [NUM_REGS*32-1:0]   cfg_regs_out,
  output logic                     cfg_we_out,
  output logic                     cfg_done_out,
  output logic                     cfg_err_out,
  output logic [31:0]              read_data_out,
  output logic                     read_valid_out
);

  localparam int               CNT_W    = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_CYCLES);

  logic             hit;
  logic             is_write;
  logic             is_read;
  logic [REG_W-1:0] index;
  logic             out_of_range;

  cfg_state_t             state_q, state_d;
  logic [CNT_W-1:0]       idle_q, idle_d;
  logic [NUM_REGS*32-1:0] regs_q;

  cgra_config_addr_decode #(
    .TILE_ID    (TILE_ID),
    .FEATURE_ID (FEATURE_ID),
    .NUM_REGS   (NUM_REGS)
  ) u_decode (
    .addr         (config_addr_in),
    .read_req     (config_read_in),
    .hit          (hit),
    .is_write     (is_write),
    .is_read      (is_read),
    .index        (index),
    .out_of_range (out_of_range)
  );

  // Next idle count and next state; any nonzero word (hit or not) restarts the idle run.
  always_comb begin
    idle_d  = idle_q;
    state_d = state_q;
    if (config_addr_in != IDLE_ADDR) begin
      idle_d = '0;
    end else if (state_q == CFG_LOAD && idle_q != IDLE_MAX) begin
      idle_d = idle_q + 1'b1;
    end
    case (state_q)
      CFG_WAIT: if (is_write) state_d = CFG_LOAD;
      CFG_LOAD: if (idle_d == IDLE_MAX) state_d = CFG_DONE;
      CFG_DONE: if (is_write) state_d = CFG_LOAD;
      default:  state_d = CFG_WAIT;
    endcase
  end

  // State and idle counter registers.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= CFG_WAIT;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
    end
  end

  // Register file write; the decoded index is compared per slot to avoid an oversized array index.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      regs_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (is_write && index == REG_W'(i)) begin
          regs_q[32*i +: 32] <= config_data_in;
        end
      end
    end
  end

  // Write strobe follows each update by one cycle; the error flag is sticky until reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cfg_we_out  <= 1'b0;
      cfg_err_out <= 1'b0;
    end else begin
      cfg_we_out <= is_write;
      if (hit && out_of_range) cfg_err_out <= 1'b1;
    end
  end

  assign cfg_regs_out = regs_q;
  assign cfg_done_out = (state_q == CFG_DONE);

`ifdef CONFIG_READBACK_EN
  logic [31:0] rd_mux;

  // Select the addressed register; out-of-range reads return zero.
  always_comb begin
    rd_mux = 32'h0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (index == REG_W'(i)) rd_mux = regs_q[32*i +: 32];
    end
  end

  // Readback response is a single-cycle pulse one cycle after the request.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      read_valid_out <= 1'b0;
      read_data_out  <= 32'h0;
    end else begin
      read_valid_out <= is_read;
      read_data_out  <= is_read ? rd_mux : 32'h0;
    end
  end
`else
  logic unused_is_read;
  assign unused_is_read = is_read;
  assign read_valid_out = 1'b0;
  assign read_data_out  = 32'h0;
`endif

endmodule

// File: tb/tb_cgra_config_responder.sv
// tb/tb_cgra_config_responder.sv - scoreboard bench for cgra_config_responder (CONFIG_READBACK_EN aware)
module tb_cgra_config_responder;

  logic         clk;
  logic         reset;
  logic [31:0]  addr;
  logic [31:0]  data;
  logic         rd;
  logic [255:0] regs;
  logic         we;
  logic         done;
  logic         err;
  logic [31:0]  rdata;
  logic         rvalid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

`ifdef CONFIG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct {
    logic         we;
    logic         done;
    logic         err;
    logic         rv;
    logic [31:0]  rdata;
    logic [255:0] regs;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;

  // Reference model state
  logic [255:0] m_regs  = '0;
  int           m_state = 0;
  int           m_cnt   = 0;
  logic         m_err   = 1'b0;

  cgra_config_responder #(
    .TILE_ID     (16'h0001),
    .FEATURE_ID  (8'h00),
    .NUM_REGS    (8),
    .IDLE_CYCLES (4)
  ) dut (
    .clk_in         (clk),
    .reset_in       (reset),
    .config_addr_in (addr),
    .config_data_in (data),
    .config_read_in (rd),
    .cfg_regs_out   (regs),
    .cfg_we_out     (we),
    .cfg_done_out   (done),
    .cfg_err_out    (err),
    .read_data_out  (rdata),
    .read_valid_out (rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one word at the falling edge, advance the model, queue its expectation, then settle after the next rise.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic r, input logic rst);
    exp_t e;
    logic hit;
    int   idx;
    logic rmode;
    @(negedge clk);
    addr  = a;
    data  = d;
    rd    = r;
    reset = rst;
    e.we = 1'b0; e.rv = 1'b0; e.rdata = 32'h0;
    if (rst) begin
      m_regs = '0; m_state = 0; m_cnt = 0; m_err = 1'b0;
    end else begin
      hit   = (a != 32'h0) && (a[15:0] == 16'h0001) && (a[23:16] == 8'h00);
      idx   = int'(a[31:24]);
      rmode = RB && r;
      if (hit && idx >= 8) begin
        m_err = 1'b1;
        if (rmode) e.rv = 1'b1;
      end else if (hit && rmode) begin
        e.rv    = 1'b1;
        e.rdata = m_regs[idx*32 +: 32];
      end else if (hit) begin
        m_regs[idx*32 +: 32] = d;
        e.we    = 1'b1;
        m_state = 1;
      end
      if (a != 32'h0) m_cnt = 0;
      else if (m_state == 1) begin
        if (m_cnt < 4) m_cnt++;
        if (m_cnt == 4) m_state = 2;
      end
    end
    e.done = (m_state == 2);
    e.err  = m_err;
    e.regs = m_regs;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop one expectation per cycle and compare every output.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      got_e = sb.pop_front();
      cyc++;
      checks++;
      if (we !== got_e.we) begin errors++; $display("FAIL sb_we cycle=%0d got=%b exp=%b", cyc, we, got_e.we); end
      checks++;
      if (done !== got_e.done) begin errors++; $display("FAIL sb_done cycle=%0d got=%b exp=%b", cyc, done, got_e.done); end
      checks++;
      if (err !== got_e.err) begin errors++; $display("FAIL sb_err cycle=%0d got=%b exp=%b", cyc, err, got_e.err); end
      checks++;
      if (rvalid !== got_e.rv) begin errors++; $display("FAIL sb_rvalid cycle=%0d got=%b exp=%b", cyc, rvalid, got_e.rv); end
      checks++;
      if (rdata !== got_e.rdata) begin errors++; $display("FAIL sb_rdata cycle=%0d got=%h exp=%h", cyc, rdata, got_e.rdata); end
      checks++;
      if (regs !== got_e.regs) begin errors++; $display("FAIL sb_regs cycle=%0d got=%h exp=%h", cyc, regs, got_e.regs); end
    end
  end

  task automatic test_reset;
    step(32'h0, 32'h0, 1'b0, 1'b1);
    step(32'h0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (regs !== 256'h0) begin errors++; $display("FAIL reset_regs got=%h exp=0", regs); end
    checks++;
    if ({we, done, err, rvalid} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {we, done, err, rvalid}); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    for (int i = 0; i < 3; i++) step(32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL wait_idle_done got=%b exp=0", done); end
  endtask

  task automatic test_write_done;
    step(32'h0300_0001, 32'hDEAD_BEEF, 1'b0, 1'b0);
    checks++;
    if (regs[3*32 +: 32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_reg3 got=%h exp=deadbeef", regs[3*32 +: 32]); end
    checks++;
    if (we !== 1'b1) begin errors++; $display("FAIL write_we got=%b exp=1", we); end
    for (int i = 0; i < 3; i++) begin
      step(32'h0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL early_done idle=%0d got=%b exp=0", i + 1, done); end
    end
    checks++;
    if (we !== 1'b0) begin errors++; $display("FAIL we_single_pulse got=%b exp=0", we); end
    step(32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_on_4th got=%b exp=1", done); end
  endtask

  task automatic test_nonhit;
    step(32'h0100_0001, 32'h0000_0011, 1'b0, 1'b0);
    step(32'h0, 32'h0, 1'b0, 1'b0);
    step(32'h0, 32'h0, 1'b0, 1'b0);
    step(32'h0200_0002, 32'h0000_AAAA, 1'b0, 1'b0);
    checks++;
    if (we !== 1'b0) begin errors++; $display("FAIL other_tile_we got=%b exp=0", we); end
    step(32'h0, 32'h0, 1'b0, 1'b0);
    step(32'h0, 32'h0, 1'b0, 1'b0);
    step(32'h0201_0001, 32'h0000_BBBB, 1'b0, 1'b0);
    checks++;
    if (regs[2*32 +: 32] !== 32'h0) begin errors++; $display("FAIL other_feature_reg2 got=%h exp=0", regs[2*32 +: 32]); end
    for (int i = 0; i < 3; i++) step(32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL nonhit_resets_idle got=%b exp=0", done); end
    step(32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL nonhit_done got=%b exp=1", done); end
  endtask

  task automatic test_done_rewrite;
    step(32'h0000_0001, 32'h0000_0005, 1'b0, 1'b0);
    checks++;
    if (regs[31:0] !== 32'h5) begin errors++; $display("FAIL rewrite_reg0 got=%h exp=5", regs[31:0]); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL rewrite_done_drop got=%b exp=0", done); end
    for (int i = 0; i < 4; i++) step(32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL rewrite_done_again got=%b exp=1", done); end
  endtask

  task automatic test_back_to_back;
    step(32'h0500_0001, 32'h0000_00A1, 1'b0, 1'b0);
    step(32'h0500_0001, 32'h0000_00B2, 1'b0, 1'b0);
    step(32'h0600_0001, 32'h0000_00C3, 1'b0, 1'b0);
    checks++;
    if (regs[5*32 +: 32] !== 32'hB2) begin errors++; $display("FAIL b2b_later_wins got=%h exp=b2", regs[5*32 +: 32]); end
    checks++;
    if (regs[6*32 +: 32] !== 32'hC3) begin errors++; $display("FAIL b2b_reg6 got=%h exp=c3", regs[6*32 +: 32]); end
    step(32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (we !== 1'b0) begin errors++; $display("FAIL b2b_we_end got=%b exp=0", we); end
  endtask

  task automatic test_readback;
    for (int i = 0; i < 4; i++) step(32'h0, 32'h0, 1'b0, 1'b0);
    step(32'h0300_0001, 32'h1234_5678, 1'b1, 1'b0);
`ifdef CONFIG_READBACK_EN
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_resp got=%b/%h exp=1/deadbeef", rvalid, rdata); end
    checks++;
    if (done !== 1'b1 || regs[3*32 +: 32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_no_side_effect got=%b/%h exp=1/deadbeef", done, regs[3*32 +: 32]); end
    step(32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL read_one_cycle got=%b exp=0", rvalid); end
    step(32'h0A00_0001, 32'h0, 1'b1, 1'b0);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0 || err !== 1'b1) begin errors++; $display("FAIL read_oor got=%b/%h/%b exp=1/0/1", rvalid, rdata, err); end
`else
    checks++;
    if (regs[3*32 +: 32] !== 32'h1234_5678) begin errors++; $display("FAIL noread_writes got=%h exp=12345678", regs[3*32 +: 32]); end
    checks++;
    if (we !== 1'b1 || done !== 1'b0 || rvalid !== 1'b0) begin errors++; $display("FAIL noread_flags got=%b%b%b exp=100", we, done, rvalid); end
`endif
  endtask

  task automatic test_error_reset;
    step(32'h0900_0001, 32'h0000_0BAD, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1 || we !== 1'b0) begin errors++; $display("FAIL err_set got=%b/%b exp=1/0", err, we); end
    step(32'h0, 32'h0, 1'b0, 1'b0);
    step(32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
    step(32'h0200_0001, 32'h0000_0007, 1'b0, 1'b0);
    step(32'h0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (regs !== 256'h0 || {we, done, err, rvalid} !== 4'b0000) begin errors++; $display("FAIL midstream_reset got=%h/%b exp=0/0000", regs, {we, done, err, rvalid}); end
    for (int i = 0; i < 5; i++) step(32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_to_wait got=%b exp=0", done); end
  endtask

  initial begin
    reset = 1'b1;
    addr  = 32'h0;
    data  = 32'h0;
    rd    = 1'b0;
    test_reset();
    test_write_done();
    test_nonhit();
    test_done_rewrite();
    test_back_to_back();
    test_readback();
    test_error_reset();
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
